// File: rtl/ring_sequence_checker_pkg.sv
// Shared constants for the one-hot ring counter and its receive-side checker.
// FSM state codes and default ring geometry live here so both ends agree.
package ring_sequence_checker_pkg;

    localparam int DEF_WIDTH    = 3;
    localparam int DEF_LOCK_CNT = 2;
    localparam int DEF_CNT_W    = 8;

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    typedef enum logic [1:0] {
        SEARCH = ST_SEARCH,
        VERIFY = ST_VERIFY,
        LOCKED = ST_LOCKED
    } state_t;

endpackage

// File: rtl/ring_sequence_checker_onehot_decoder.sv
// Combinational one-hot decoder: binary position of the hot bit plus a flag
// that is set only when exactly one bit of the input vector is high.
module onehot_decoder
    import ring_sequence_checker_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             is_onehot
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
        // Clearing the lowest set bit leaves zero only for a single-bit vector.
        is_onehot = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);
    end

endmodule

// File: rtl/ring_sequence_checker.sv
// Receive-side checker for a one-hot ring sequence: decodes the hot bit,
// verifies each sample is the previous one rotated left, and tracks lock.
module ring_sequence_checker
    import ring_sequence_checker_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int CNT_W    = DEF_CNT_W,
    localparam int IDX_W   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] seq_in,
    output logic [IDX_W-1:0] index,
    output logic             index_valid,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] err_count
);

    localparam int GC_W = $clog2(LOCK_CNT + 1);

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [GC_W-1:0]  good_cnt;

    logic [IDX_W-1:0] dec_idx;
    logic             is_onehot;
    logic [WIDTH-1:0] expected;
    logic             good;
    logic             bad;
    logic [GC_W-1:0]  good_inc;

    onehot_decoder #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_dec (
        .vec       (seq_in),
        .idx       (dec_idx),
        .is_onehot (is_onehot)
    );

    // A repeated sample never matches the rotation, so a stalled source is flagged.
    assign expected = {prev[WIDTH-2:0], prev[WIDTH-1]};
    assign good     = is_onehot && (seq_in == expected);
    assign bad      = sample_en && (state != SEARCH) && !good;
    assign good_inc = good_cnt + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= SEARCH;
            prev        <= '0;
            good_cnt    <= '0;
            index       <= '0;
            index_valid <= 1'b0;
            locked      <= 1'b0;
            error       <= 1'b0;
            err_count   <= '0;
        end else begin
            error <= 1'b0;
            if (sample_en) begin
                error <= bad;
                if (bad && (err_count != '1)) begin
                    err_count <= err_count + 1'b1;
                end

                if (is_onehot) begin
                    index       <= dec_idx;
                    index_valid <= 1'b1;
                    prev        <= seq_in;
                end else begin
                    index_valid <= 1'b0;
                end

                case (state)
                    SEARCH: begin
                        locked <= 1'b0;
                        if (is_onehot) begin
                            state    <= VERIFY;
                            good_cnt <= '0;
                        end
                    end
                    VERIFY: begin
                        if (good) begin
                            good_cnt <= good_inc;
                            if (good_inc == GC_W'(LOCK_CNT)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                locked <= 1'b0;
                            end
                        end else if (is_onehot) begin
                            good_cnt <= '0;
                            locked   <= 1'b0;
                        end else begin
                            state  <= SEARCH;
                            locked <= 1'b0;
                        end
                    end
                    LOCKED: begin
                        if (good) begin
                            locked <= 1'b1;
                        end else if (is_onehot) begin
                            state    <= VERIFY;
                            good_cnt <= '0;
                            locked   <= 1'b0;
                        end else begin
                            state  <= SEARCH;
                            locked <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/ring_sequence_checker.md
Name: ring_sequence_checker

Overview:
Receive-side companion to the team's 3-bit one-hot ring counter. It samples a one-hot ring sequence arriving from a ring-counter source and decodes the hot bit into a binary index. It checks that every new sample is the previous one rotated left by one position (MSB wraps into bit 0), and reports lock status plus an error count. It sits at the consuming end of any ring-counter-driven sequencing path, for example step selection or lab-board display scanning.

Parameters:
WIDTH, 3, ring length in bits; must be at least 2.
LOCK_CNT, 2, number of consecutive correct transitions needed to declare lock; must be at least 1.
CNT_W, 8, width of the saturating error counter.
IDX_W, $clog2(WIDTH), index width; derived, not overridden.

Ports:
clock  input  1  single system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset; takes priority over every other input.
sample_en  input  1  seq_in is valid and is evaluated this cycle.
seq_in  input  WIDTH  ring sequence sample.
index  output  IDX_W  position of the hot bit in the last valid one-hot sample.
index_valid  output  1  last evaluated sample was one-hot.
locked  output  1  FSM is in LOCKED.
error  output  1  one-cycle pulse marking a bad sample.
err_count  output  CNT_W  saturating count of error pulses.

Behaviour:
- Reset values: index 0, index_valid 0, locked 0, error 0, err_count 0, prev 0, good_cnt 0, state SEARCH.
- Timing: all outputs are registered. The response to a sample appears one cycle after the edge where sample_en=1 is seen.
- sample_en=0: all state and outputs hold, except error, which is 0.
- One-hot test: a sample passes only if exactly one bit is set. All-zero or multi-hot samples fail.
  - Pass: index <= hot position, index_valid <= 1.
  - Fail: index_valid <= 0, index holds its previous value.
- Expected next value: {prev[WIDTH-2:0], prev[WIDTH-1]}.
  - A sample is "good" if it passes the one-hot test and equals the expected value.
  - On every one-hot sample, prev <= seq_in.
- FSM, with all transitions evaluated only when sample_en=1:
  - SEARCH:
    - One-hot sample: go to VERIFY, good_cnt <= 0.
    - Non-one-hot sample: stay in SEARCH, no error.
  - VERIFY:
    - Good sample: good_cnt + 1. If that reaches LOCK_CNT, go to LOCKED.
    - One-hot mismatch: stay in VERIFY, good_cnt <= 0, error pulse.
    - Non-one-hot sample: go to SEARCH, error pulse.
  - LOCKED:
    - Good sample: stay in LOCKED.
    - One-hot mismatch: go to VERIFY, good_cnt <= 0, error pulse.
    - Non-one-hot sample: go to SEARCH, error pulse.
- locked is registered, so it equals (next_state == LOCKED) captured at the same edge as the other outputs.
- err_count increments by 1 on each error pulse and saturates at all-ones. It is never cleared except by reset.
- Repeated sample (seq_in == prev) is a mismatch. A ring source stalled while sample_en is high is therefore an error.
- Reset asserted mid-lock, or together with sample_en: reset wins and all reset values appear at the next edge.

Decomposition:
- Shared package: FSM state encoding constants (ST_SEARCH, ST_VERIFY, ST_LOCKED as 2-bit localparams) and the default WIDTH/LOCK_CNT constants, shared with the ring counter.
- One natural sub-module, onehot_decoder. It is purely combinational: WIDTH-bit input produces IDX_W-bit index plus an is_onehot flag. It is instantiated once and is reusable by other ring consumers.
- The FSM, prev register, good_cnt, and error counter live in ring_sequence_checker.

Test Plan:
1. WIDTH=3, LOCK_CNT=2. Reset, then sample_en=1 with seq_in 001, 010, 100, 001 on consecutive cycles -> index 0,1,2,0. index_valid is 1 from the first response. locked rises on the response to 100 and stays high. error never pulses.
2. While locked, drive seq_in=011 -> next cycle: error=1 for one cycle, err_count=1, locked=0, index_valid=0, index holds 0. Then 001, 010, 100 -> relocked.
3. While locked after 001, drive 100 (skips 010) -> error pulse, err_count+1, locked=0 (VERIFY). Then 001, 010 -> locked=1 again after 2 good transitions.
4. Samples 001, then sample_en=0 for 3 cycles with seq_in=111, then 010, 100 -> all outputs hold during the gap, error stays 0, locked=1 after 100.
5. CNT_W=2, locked, then 5 samples of 000 separated by relocks -> err_count reads 1,2,3,3,3. Each bad sample produces a single-cycle error pulse.
6. Locked with sample_en=1 and reset=1 on the same cycle -> next cycle index=0, index_valid=0, locked=0, error=0, err_count=0. Then 010 -> state VERIFY, no error.
